// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD
  } state_t;

  localparam int   CNT_W     = 4;
  localparam logic PORT_BOOT = 1'b0;
  localparam logic PORT_CPU  = 1'b1;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant selection between the boot loader and CPU ports.
// SRAM_ARB_FIXED_PRIO_EN: port 0 always wins a tie and no last_grant is kept.
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic issue,
  output logic grant
);

`ifdef SRAM_ARB_FIXED_PRIO_EN

  always_comb begin
    grant = PORT_BOOT;
    if (!req0 && req1) grant = PORT_CPU;
  end

`else

  logic last_grant;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant = PORT_BOOT;
    if (req0 && req1)
      grant = ~last_grant;
    else if (req1)
      grant = PORT_CPU;
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= PORT_CPU;
    else if (issue)
      last_grant <= grant;
  end

`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for an external asynchronous SRAM with fixed CS/OE/WE timing.
// SRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0) instead of round-robin.
//
// state  | meaning
// IDLE   | strobes high, waiting for a request; grant and latch on request
// SETUP  | cs low, address driven; oe low (read) or data driven (write)
// ACTIVE | ACCESS_CYCLES cycles; we low (write) or oe low (read)
// HOLD   | we high for write recovery, ack pulse to the granted port
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din
);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              cur_we, cur_we_d;
  logic              cur_port, cur_port_d;
  logic              grant;
  logic              issue;

  logic              cs_n_d, oe_n_d, we_n_d, dout_en_d, ack0_d, ack1_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d, rdata_d;

  sram_arb_grant u_grant (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .issue (issue),
    .grant (grant)
  );

  // Next-state logic computes the outputs for the state being entered, so every
  // pin is a flop and changes together with the state.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cur_we_d   = cur_we;
    cur_port_d = cur_port;
    issue      = 1'b0;
    cs_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    dout_en_d  = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    addr_d     = sram_addr;
    dout_d     = sram_dout;
    rdata_d    = rdata;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          issue      = 1'b1;
          state_d    = SETUP;
          cur_port_d = grant;
          cur_we_d   = (grant == PORT_CPU) ? we1 : we0;
          addr_d     = (grant == PORT_CPU) ? addr1 : addr0;
          cs_n_d     = 1'b0;
          if (cur_we_d) begin
            dout_en_d = 1'b1;
            dout_d    = (grant == PORT_CPU) ? wdata1 : wdata0;
          end else begin
            oe_n_d = 1'b0;
          end
        end
      end

      SETUP: begin
        state_d = ACTIVE;
        cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
        cs_n_d  = 1'b0;
        if (cur_we) begin
          we_n_d    = 1'b0;
          dout_en_d = 1'b1;
        end else begin
          oe_n_d = 1'b0;
        end
      end

      ACTIVE: begin
        cs_n_d = 1'b0;
        if (cur_we) dout_en_d = 1'b1;
        else        oe_n_d    = 1'b0;
        if (cnt == '0) begin
          state_d = HOLD;
          if (!cur_we) rdata_d = sram_din;
          ack0_d = (cur_port == PORT_BOOT);
          ack1_d = (cur_port == PORT_CPU);
        end else begin
          cnt_d = cnt - CNT_W'(1);
          if (cur_we) we_n_d = 1'b0;
        end
      end

      HOLD: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_we       <= 1'b0;
      cur_port     <= PORT_BOOT;
      sram_cs_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_dout_en <= 1'b0;
      sram_addr    <= '0;
      sram_dout    <= '0;
      rdata        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      cur_we       <= cur_we_d;
      cur_port     <= cur_port_d;
      sram_cs_n    <= cs_n_d;
      sram_oe_n    <= oe_n_d;
      sram_we_n    <= we_n_d;
      sram_dout_en <= dout_en_d;
      sram_addr    <= addr_d;
      sram_dout    <= dout_d;
      rdata        <= rdata_d;
      ack0         <= ack0_d;
      ack1         <= ack1_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM and access-level reference model.
module tb_sram_arbiter;

  localparam int AC = 2;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [17:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  rdata;
  logic        sram_cs_n, sram_oe_n, sram_we_n, sram_dout_en;
  logic [17:0] sram_addr;
  logic [7:0]  sram_dout, sram_din;

  logic [7:0]  sram_mem [0:(1<<18)-1];
  logic [7:0]  exp_mem [int];
  logic [17:0] pool [8];
  logic        f_we [2];
  logic [17:0] f_addr [2];
  logic [7:0]  f_wd [2];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_port = 1;
  logic [7:0]  exp_rdata = 8'h00;

  sram_arbiter #(.ADDR_W(18), .DATA_W(8), .ACCESS_CYCLES(AC)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .ack0         (ack0),
    .ack1         (ack1),
    .rdata        (rdata),
    .sram_cs_n    (sram_cs_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_addr    (sram_addr),
    .sram_dout    (sram_dout),
    .sram_dout_en (sram_dout_en),
    .sram_din     (sram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: reads while CS and OE are low, writes on the rising edge of WE.
  assign sram_din = (sram_cs_n === 1'b0 && sram_oe_n === 1'b0) ? sram_mem[sram_addr] : 8'hEE;
  always @(posedge sram_we_n)
    if (sram_cs_n === 1'b0 && sram_dout_en === 1'b1) sram_mem[sram_addr] <= sram_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_port(input int p, input logic r, input logic w,
                            input logic [17:0] a, input logic [7:0] d);
    f_we[p] = w; f_addr[p] = a; f_wd[p] = d;
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic rand_fields(input int p);
    drive_port(p, 1'b1, 1'($urandom % 2), pool[$urandom % 8], 8'($urandom));
  endtask

  task automatic idle(input int n);
    step();
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 1; i < n; i++) step();
  endtask

  // One access from a single requesting port; returns the cycle of its ack.
  task automatic do_access(input int p, input logic w, input logic [17:0] a,
                           input logic [7:0] d, output int ack_at);
    int   start, n_cs, n_oe, n_we, n_en, bad, other;
    logic got;
    step();
    chk("gap_idle_cs", {31'd0, sram_cs_n}, 1);
    chk("ack_one_cycle", {30'd0, ack1, ack0}, 0);
    drive_port(p, 1'b1, w, a, d);
    drive_port(1 - p, 1'b0, 1'b0, '0, '0);
    start = cyc; got = 1'b0;
    n_cs = 0; n_oe = 0; n_we = 0; n_en = 0; bad = 0; other = 0;
    for (int i = 0; i < 4 * AC + 12 && !got; i++) begin
      step();
      if (!sram_cs_n) n_cs++;
      if (!sram_oe_n) n_oe++;
      if (!sram_we_n) n_we++;
      if (sram_dout_en) n_en++;
      if (!sram_cs_n && sram_addr !== a) bad++;
      if (!sram_we_n && sram_dout !== d) bad++;
      if ((p == 0) ? ack1 : ack0) other++;
      if ((p == 0) ? ack0 : ack1) got = 1'b1;
    end
    chk("ack_seen", {31'd0, got}, 1);
    chk("ack_latency", cyc - start, AC + 2);
    chk("cs_low_cycles", n_cs, AC + 2);
    chk("oe_low_cycles", n_oe, w ? 0 : AC + 2);
    chk("we_low_cycles", n_we, w ? AC : 0);
    chk("dout_en_cycles", n_en, w ? AC + 2 : 0);
    chk("pin_addr_data", bad, 0);
    chk("wrong_port_ack", other, 0);
    last_port = p;
    if (w) begin
      exp_mem[int'(a)] = d;
      chk("mem_written", {24'd0, sram_mem[a]}, {24'd0, d});
    end else begin
      exp_rdata = exp_mem[int'(a)];
    end
    chk("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
    ack_at = cyc;
  endtask

  // Both ports request continuously; the fields of the port just served are renewed.
  task automatic contention(input int n);
    int   start, p, exp_p, both;
    logic got;
    step();
    chk("cont_idle_cs", {31'd0, sram_cs_n}, 1);
    rand_fields(0);
    rand_fields(1);
    start = cyc;
    for (int k = 0; k < n; k++) begin
      got = 1'b0; both = 0;
      for (int i = 0; i < 4 * AC + 12 && !got; i++) begin
        step();
        if (ack0 && ack1) both++;
        if (ack0 || ack1) got = 1'b1;
      end
      chk("cont_ack_seen", {31'd0, got}, 1);
      chk("cont_no_overlap", both, 0);
      chk("cont_latency", cyc - start, AC + 2);
      p = ack1 ? 1 : 0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      exp_p = 0;
`else
      exp_p = 1 - last_port;
`endif
      chk("cont_grant", p, exp_p);
      last_port = exp_p;
      if (f_we[exp_p]) begin
        exp_mem[int'(f_addr[exp_p])] = f_wd[exp_p];
        chk("cont_mem", {24'd0, sram_mem[f_addr[exp_p]]}, {24'd0, f_wd[exp_p]});
      end else begin
        exp_rdata = exp_mem[int'(f_addr[exp_p])];
      end
      chk("cont_rdata", {24'd0, rdata}, {24'd0, exp_rdata});
      if (k < n - 1) begin
        step();
        chk("cont_idle_cs", {31'd0, sram_cs_n}, 1);
        rand_fields(exp_p);
        start = cyc;
      end
    end
  endtask

  task automatic reset_mid_active();
    int acks;
    step();
    drive_port(0, 1'b1, 1'b1, 18'h00777, 8'h3C);
    drive_port(1, 1'b0, 1'b0, '0, '0);
    step();
    chk("rst_setup_cs", {31'd0, sram_cs_n}, 0);
    step();
    chk("rst_active_we", {31'd0, sram_we_n}, 0);
    reset = 1'b1;
    step();
    chk("rst_we_n", {31'd0, sram_we_n}, 1);
    chk("rst_cs_n", {31'd0, sram_cs_n}, 1);
    chk("rst_oe_n", {31'd0, sram_oe_n}, 1);
    chk("rst_dout_en", {31'd0, sram_dout_en}, 0);
    chk("rst_ack", {30'd0, ack1, ack0}, 0);
    reset = 1'b0;
    drive_port(0, 1'b0, 1'b0, '0, '0);
    acks = 0;
    for (int i = 0; i < AC + 4; i++) begin
      step();
      if (ack0 || ack1) acks++;
    end
    chk("rst_no_ack", acks, 0);
    last_port = 1;
    exp_rdata = 8'h00;
    chk("rst_rdata", {24'd0, rdata}, {24'd0, exp_rdata});
  endtask

  initial begin
    int t0, t1;
    logic [7:0] v;
    reset = 1'b1;
    drive_port(0, 1'b0, 1'b0, '0, '0);
    drive_port(1, 1'b0, 1'b0, '0, '0);
    pool[0] = 18'h01234; pool[1] = 18'h3FFFF; pool[2] = 18'h00010; pool[3] = 18'h1ABCD;
    pool[4] = 18'h2F0F0; pool[5] = 18'h12345; pool[6] = 18'h3C3C3; pool[7] = 18'h08008;
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 8'hA5 : 8'($urandom);
      sram_mem[pool[i]] = v;
      exp_mem[int'(pool[i])] = v;
    end

    repeat (3) step();
    chk("reset_cs_n", {31'd0, sram_cs_n}, 1);
    chk("reset_oe_n", {31'd0, sram_oe_n}, 1);
    chk("reset_we_n", {31'd0, sram_we_n}, 1);
    chk("reset_dout_en", {31'd0, sram_dout_en}, 0);
    chk("reset_addr", {14'd0, sram_addr}, 0);
    chk("reset_dout", {24'd0, sram_dout}, 0);
    chk("reset_rdata", {24'd0, rdata}, 0);
    chk("reset_ack", {30'd0, ack1, ack0}, 0);
    reset = 1'b0;
    step();

    do_access(1, 1'b0, 18'h01234, 8'h00, t0);
    do_access(0, 1'b1, 18'h3FFFF, 8'h5A, t0);
    idle(2);

    do_access(1, 1'($urandom % 2), pool[$urandom % 8], 8'($urandom), t0);
    for (int k = 0; k < 3; k++) begin
      do_access(1, 1'($urandom % 2), pool[$urandom % 8], 8'($urandom), t1);
      chk("b2b_period", t1 - t0, AC + 3);
      t0 = t1;
    end
    idle(2);

    for (int k = 0; k < 12; k++) begin
      do_access(int'($urandom % 2), 1'($urandom % 2), pool[$urandom % 8], 8'($urandom), t0);
      if ($urandom % 2 == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(1);

    contention(4);
    do_access(1, 1'b0, pool[$urandom % 8], 8'h00, t0);
    idle(2);

    reset_mid_active();
    do_access(0, 1'b0, pool[$urandom % 8], 8'h00, t0);
    do_access(1, 1'b1, pool[$urandom % 8], 8'($urandom), t0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
